// File: rtl/conv_window_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : conv_window_addr_gen
//  Description : Sweeps a pixel index across one frame. For each position it
//                presents KROWS tap addresses, ROW_STRIDE words apart, under a
//                valid/ready handshake. Supports single-shot and continuous
//                frames, synchronous clear and asynchronous reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_window_addr_gen #(
    parameter int ADDR_W     = 16,
    parameter int KROWS      = 5,
    parameter int ROW_STRIDE = 11520,
    parameter int NUM_POS    = 11520,
    parameter int BASE       = 0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      cont,
    input  logic                      clear,
    input  logic                      addr_ready,
    output logic                      addr_valid,
    output logic [KROWS*ADDR_W-1:0]   addr_bus,
    output logic [ADDR_W-1:0]         pos,
    output logic                      frame_done,
    output logic [7:0]                frame_cnt,
    output logic                      busy
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Index of the final position of a frame.
    localparam logic [ADDR_W-1:0] c_LAST_POS = ADDR_W'(NUM_POS - 1);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pos_q, pos_d;
    logic               frame_done_q, frame_done_d;
    logic [7:0]         frame_cnt_q, frame_cnt_d;

    // State, position and frame bookkeeping registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            pos_q        <= '0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            pos_q        <= pos_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    // Next-state logic: clear dominates, then start (IDLE) or handshake (RUN).
    always_comb begin
        state_d      = state_q;
        pos_d        = pos_q;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;

        if (clear) begin
            state_d = S_IDLE;
            pos_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_RUN;
                        pos_d   = '0;
                    end
                end
                S_RUN: begin
                    // addr_valid is implied high in RUN, so ready alone
                    // completes the handshake.
                    if (addr_ready) begin
                        if (pos_q == c_LAST_POS) begin
                            frame_done_d = 1'b1;
                            frame_cnt_d  = frame_cnt_q + 8'd1;
                            pos_d        = '0;
                            if (!cont) begin
                                state_d = S_IDLE;
                            end
                        end else begin
                            pos_d = pos_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    pos_d   = '0;
                end
            endcase
        end
    end

    // Tap addresses: per-tap offsets are elaboration-time constants; the add
    // is done at ADDR_W bits so any carry out is silently discarded (wrap).
    generate
        for (genvar k = 0; k < KROWS; k++) begin : g_tap
            localparam logic [ADDR_W-1:0] c_TAP_OFF = ADDR_W'(BASE + k * ROW_STRIDE);
            assign addr_bus[k*ADDR_W +: ADDR_W] = c_TAP_OFF + pos_q;
        end
    endgenerate

    assign addr_valid = (state_q == S_RUN);
    assign busy       = (state_q == S_RUN);
    assign pos        = pos_q;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_window_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_window_addr_gen
//  Description : Self-checking bench for conv_window_addr_gen. Three instances
//                (default, small frame, 8-bit wrapping) share stimulus and are
//                compared every cycle against a behavioural frame model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_window_addr_gen;

    logic clk = 1'b0;
    logic reset_n;
    logic start, cont, clear, addr_ready;

    always #5 clk = ~clk;

    // Instance 0: default parameters
    logic        v0, fd0, b0;
    logic [79:0] bus0;
    logic [15:0] pos0;
    logic [7:0]  fc0;
    // Instance 1: KROWS=3, ROW_STRIDE=10, NUM_POS=4
    logic        v1, fd1, b1;
    logic [47:0] bus1;
    logic [15:0] pos1;
    logic [7:0]  fc1;
    // Instance 2: ADDR_W=8, BASE=250, ROW_STRIDE=3, KROWS=3, NUM_POS=6
    logic        v2, fd2, b2;
    logic [23:0] bus2;
    logic [7:0]  pos2;
    logic [7:0]  fc2;

    conv_window_addr_gen u_dut0 (
        .clk(clk), .reset_n(reset_n), .start(start), .cont(cont), .clear(clear),
        .addr_ready(addr_ready), .addr_valid(v0), .addr_bus(bus0), .pos(pos0),
        .frame_done(fd0), .frame_cnt(fc0), .busy(b0)
    );

    conv_window_addr_gen #(.ADDR_W(16), .KROWS(3), .ROW_STRIDE(10), .NUM_POS(4), .BASE(0)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(start), .cont(cont), .clear(clear),
        .addr_ready(addr_ready), .addr_valid(v1), .addr_bus(bus1), .pos(pos1),
        .frame_done(fd1), .frame_cnt(fc1), .busy(b1)
    );

    conv_window_addr_gen #(.ADDR_W(8), .KROWS(3), .ROW_STRIDE(3), .NUM_POS(6), .BASE(250)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .start(start), .cont(cont), .clear(clear),
        .addr_ready(addr_ready), .addr_valid(v2), .addr_bus(bus2), .pos(pos2),
        .frame_done(fd2), .frame_cnt(fc2), .busy(b2)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- configuration of each instance ----------------
    function automatic longint p_n(input int i);
        case (i) 0: return 11520; 1: return 4; default: return 6; endcase
    endfunction
    function automatic int p_kr(input int i);
        case (i) 0: return 5; default: return 3; endcase
    endfunction
    function automatic int p_aw(input int i);
        case (i) 2: return 8; default: return 16; endcase
    endfunction
    function automatic longint p_st(input int i);
        case (i) 0: return 11520; 1: return 10; default: return 3; endcase
    endfunction
    function automatic longint p_base(input int i);
        case (i) 2: return 250; default: return 0; endcase
    endfunction

    // ---------------- behavioural model ----------------
    bit     m_run [3];
    longint m_pos [3];
    bit     m_fd  [3];
    longint m_fc  [3];

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_run[i] = 0; m_pos[i] = 0; m_fd[i] = 0; m_fc[i] = 0;
        end
    endtask

    // One clock edge of the frame sweep, using the inputs seen at that edge.
    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            m_fd[i] = 0;
            if (clear) begin
                m_run[i] = 0;
                m_pos[i] = 0;
            end else if (!m_run[i]) begin
                if (start) begin
                    m_run[i] = 1;
                    m_pos[i] = 0;
                end
            end else if (addr_ready) begin
                if (m_pos[i] == p_n(i) - 1) begin
                    m_fd[i]  = 1;
                    m_fc[i]  = (m_fc[i] + 1) % 256;
                    m_pos[i] = 0;
                    m_run[i] = cont;
                end else begin
                    m_pos[i] = m_pos[i] + 1;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            logic [127:0] bw;
            longint v, p, fd, fc, b, mask, exp_a;
            case (i)
                0: begin bw = 128'(bus0); v = v0; p = pos0; fd = fd0; fc = fc0; b = b0; end
                1: begin bw = 128'(bus1); v = v1; p = pos1; fd = fd1; fc = fc1; b = b1; end
                default: begin bw = 128'(bus2); v = v2; p = pos2; fd = fd2; fc = fc2; b = b2; end
            endcase
            check_val($sformatf("i%0d addr_valid", i), v, longint'(m_run[i]));
            check_val($sformatf("i%0d busy", i), b, longint'(m_run[i]));
            check_val($sformatf("i%0d pos", i), p, m_pos[i]);
            check_val($sformatf("i%0d frame_done", i), fd, longint'(m_fd[i]));
            check_val($sformatf("i%0d frame_cnt", i), fc, m_fc[i]);
            mask = (longint'(1) << p_aw(i)) - 1;
            for (int k = 0; k < p_kr(i); k++) begin
                exp_a = (p_base(i) + m_pos[i] + longint'(k) * p_st(i)) % (longint'(1) << p_aw(i));
                check_val($sformatf("i%0d tap%0d", i, k),
                          longint'(bw >> (k * p_aw(i))) & mask, exp_a);
            end
        end
    endtask

    // Apply inputs, advance one edge, then compare on the falling edge.
    task automatic cycle(input logic s, input logic c, input logic cl, input logic r);
        start = s; cont = c; clear = cl; addr_ready = r;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    // Asynchronous reset pulse issued between clock edges.
    task automatic reset_pulse();
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        @(negedge clk);
        check_all();
        reset_n = 1'b1;
    endtask

    int fd_cnt;
    int busy_drops;

    initial begin
        reset_n = 1'b0; start = 0; cont = 0; clear = 0; addr_ready = 0;
        model_reset();
        repeat (2) @(negedge clk);
        // Reset state of the default instance.
        check_all();
        check_val("rst valid0", longint'(v0), 0);
        check_val("rst pos0", longint'(pos0), 0);
        check_val("rst fc0", longint'(fc0), 0);
        check_val("rst tap0", longint'(bus0[0 +: 16]), 0);
        check_val("rst tap1", longint'(bus0[16 +: 16]), 11520);
        check_val("rst tap2", longint'(bus0[32 +: 16]), 23040);
        check_val("rst tap3", longint'(bus0[48 +: 16]), 34560);
        check_val("rst tap4", longint'(bus0[64 +: 16]), 46080);
        reset_n = 1'b1;

        // Single frame with ready held high.
        cycle(1, 0, 0, 1);
        check_val("sf pos0", longint'(pos1), 0);
        check_val("sf valid", longint'(v1), 1);
        cycle(0, 0, 0, 1);
        check_val("sf pos1", longint'(pos1), 1);
        cycle(0, 0, 0, 1);
        check_val("sf pos2", longint'(pos1), 2);
        check_val("sf tap0@2", longint'(bus1[0 +: 16]), 2);
        check_val("sf tap1@2", longint'(bus1[16 +: 16]), 12);
        check_val("sf tap2@2", longint'(bus1[32 +: 16]), 22);
        cycle(0, 0, 0, 1);
        check_val("sf pos3", longint'(pos1), 3);
        cycle(0, 0, 0, 1);
        check_val("sf frame_done", longint'(fd1), 1);
        check_val("sf frame_cnt", longint'(fc1), 1);
        check_val("sf idle", longint'(b1), 0);
        // 8-bit instance is now at position 4 and wraps.
        check_val("wrap pos", longint'(pos2), 4);
        check_val("wrap tap0", longint'(bus2[0 +: 8]), 254);
        check_val("wrap tap1", longint'(bus2[8 +: 8]), 1);
        check_val("wrap tap2", longint'(bus2[16 +: 8]), 4);
        cycle(0, 0, 0, 1);
        check_val("sf fd single", longint'(fd1), 0);

        // Backpressure at position 1.
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 1);
        for (int j = 0; j < 3; j++) begin
            cycle(0, 0, 0, 0);
            check_val("bp pos", longint'(pos1), 1);
            check_val("bp valid", longint'(v1), 1);
            check_val("bp tap0", longint'(bus1[0 +: 16]), 1);
            check_val("bp tap1", longint'(bus1[16 +: 16]), 11);
            check_val("bp tap2", longint'(bus1[32 +: 16]), 21);
        end
        cycle(0, 0, 0, 1);
        check_val("bp resume", longint'(pos1), 2);

        // Clear together with a handshake at position 2.
        cycle(0, 0, 1, 1);
        check_val("clr busy", longint'(b1), 0);
        check_val("clr pos", longint'(pos1), 0);
        check_val("clr fd", longint'(fd1), 0);

        // Continuous mode: three frames back-to-back.
        cycle(1, 1, 0, 1);
        fd_cnt = 0;
        busy_drops = 0;
        for (int j = 1; j <= 12; j++) begin
            cycle(0, 1, 0, 1);
            if (fd1) fd_cnt++;
            if (!b1) busy_drops++;
            check_val($sformatf("cont fd@%0d", j), longint'(fd1), (j % 4 == 0) ? 1 : 0);
        end
        check_val("cont fd count", fd_cnt, 3);
        check_val("cont busy drops", busy_drops, 0);
        check_val("cont fc", longint'(fc1), 4);
        repeat (4) cycle(0, 0, 0, 1);
        check_val("cont end idle", longint'(b1), 0);

        // Asynchronous reset in the middle of a frame.
        cycle(1, 0, 0, 1);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        reset_n = 1'b0;
        #1;
        check_val("arst busy", longint'(b1), 0);
        check_val("arst valid", longint'(v1), 0);
        check_val("arst fc", longint'(fc1), 0);
        check_val("arst pos", longint'(pos1), 0);
        reset_pulse();

        // Randomized traffic.
        for (int j = 0; j < 3000; j++) begin
            if ($urandom_range(0, 299) == 0) begin
                reset_pulse();
            end else begin
                cycle(($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0,
                      ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                      ($urandom_range(0, 47) == 0) ? 1'b1 : 1'b0,
                      ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
